// File: rtl/vending_pkg.sv
// Shared types, encodings and defaults for the two-drink vending controller.
package vending_pkg;

    localparam int unsigned MONEY_W         = 6;
    localparam int unsigned PRICE_1_DEF     = 5;
    localparam int unsigned PRICE_2_DEF     = 10;
    localparam int unsigned SHOW_CYCLES_DEF = 4;

    localparam logic [MONEY_W-1:0] MONEY_MAX = '1;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        S1   = 3'd1,
        S2   = 3'd2,
        S3   = 3'd3,
        SHOW = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        COIN_NONE = 2'b00,
        COIN_1Y   = 2'b01,
        COIN_10Y  = 2'b10,
        COIN_HALF = 2'b11
    } coin_t;

    // Coin values in Q1 (value = yuan x 2)
    localparam logic [MONEY_W-1:0] Q1_1Y   = 6'd2;
    localparam logic [MONEY_W-1:0] Q1_10Y  = 6'd20;
    localparam logic [MONEY_W-1:0] Q1_HALF = 6'd1;

    typedef enum logic [1:0] {
        OP_NONE = 2'b00,
        OP_D1   = 2'b01,
        OP_D2   = 2'b10,
        OP_RSVD = 2'b11
    } drink_op_t;

    // Decode a coin code into its Q1 value
    function automatic logic [MONEY_W-1:0] coin_q1(input logic [1:0] cv);
        logic [MONEY_W-1:0] val;
        case (coin_t'(cv))
            COIN_1Y:   val = Q1_1Y;
            COIN_10Y:  val = Q1_10Y;
            COIN_HALF: val = Q1_HALF;
            default:   val = '0;
        endcase
        return val;
    endfunction

    // Map a credit value onto the credit band states
    function automatic state_t credit_state(input logic [MONEY_W-1:0] credit,
                                            input logic [MONEY_W-1:0] p1,
                                            input logic [MONEY_W-1:0] p2);
        state_t st;
        if (credit == '0)     st = IDLE;
        else if (credit < p1) st = S1;
        else if (credit < p2) st = S2;
        else                  st = S3;
        return st;
    endfunction

endpackage

// File: rtl/vending_fsm_if.sv
// Front-panel inputs and display/LED outputs of the vending controller.
interface vending_fsm_if;
    import vending_pkg::*;

    logic               insert;
    logic [1:0]         coin_val;
    logic [1:0]         drink_op;
    logic               cancel_flag;
    logic               hold_ind;
    logic               drink_1_ind;
    logic               drink_2_ind;
    logic               drinktk_ind;
    logic               charge_ind;
    logic [MONEY_W-1:0] coin_sum;

    // Panel side: drives strobes, reads indicators
    modport master (
        output insert, coin_val, drink_op, cancel_flag,
        input  hold_ind, drink_1_ind, drink_2_ind, drinktk_ind, charge_ind, coin_sum
    );

    // Controller side
    modport slave (
        input  insert, coin_val, drink_op, cancel_flag,
        output hold_ind, drink_1_ind, drink_2_ind, drinktk_ind, charge_ind, coin_sum
    );

endinterface

// File: rtl/vending_coin_acc.sv
// Saturating Q1 credit accumulator with coin decode.
module vending_coin_acc
    import vending_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clr,
    input  logic               add_en,
    input  logic [1:0]         coin_val,
    output logic [MONEY_W-1:0] credit,
    output logic [MONEY_W-1:0] credit_nxt_c
);

    logic [MONEY_W:0] sum_c;

    // Next credit: clear wins over add; add saturates at MONEY_MAX
    always_comb begin
        sum_c        = {1'b0, credit} + {1'b0, coin_q1(coin_val)};
        credit_nxt_c = credit;
        if (clr) begin
            credit_nxt_c = '0;
        end else if (add_en) begin
            credit_nxt_c = sum_c[MONEY_W] ? MONEY_MAX : sum_c[MONEY_W-1:0];
        end
    end

    // Credit register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) credit <= '0;
        else        credit <= credit_nxt_c;
    end

endmodule

// File: rtl/vending_fsm.sv
// Two-drink vending controller: credit bands, selection, refund and result display.
module vending_fsm
    import vending_pkg::*;
#(
    parameter int unsigned PRICE_1     = PRICE_1_DEF,
    parameter int unsigned PRICE_2     = PRICE_2_DEF,
    parameter int unsigned SHOW_CYCLES = SHOW_CYCLES_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    vending_fsm_if.slave  bus
);

    localparam logic [MONEY_W-1:0] P1       = MONEY_W'(PRICE_1);
    localparam logic [MONEY_W-1:0] P2       = MONEY_W'(PRICE_2);
    localparam int unsigned        CNT_W    = $clog2(SHOW_CYCLES + 1);
    localparam logic [CNT_W-1:0]   CNT_LOAD = CNT_W'(SHOW_CYCLES - 1);

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [MONEY_W-1:0] result, result_nxt;
    logic               take, take_nxt;

    logic               clr, add_en;
    logic [MONEY_W-1:0] credit, credit_nxt_c;
    logic               sel_ok;
    logic [MONEY_W-1:0] sel_price;

    logic               hold_q, d1_q, d2_q, tk_q, ch_q;
    logic [MONEY_W-1:0] sum_q;
    logic               hold_nxt, d1_nxt, d2_nxt, tk_nxt, ch_nxt;
    logic [MONEY_W-1:0] sum_nxt;

    vending_coin_acc u_acc (
        .clk          (clk),
        .rst_n        (rst_n),
        .clr          (clr),
        .add_en       (add_en),
        .coin_val     (bus.coin_val),
        .credit       (credit),
        .credit_nxt_c (credit_nxt_c)
    );

    // State, show counter and latched result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            result <= '0;
            take   <= 1'b0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            result <= result_nxt;
            take   <= take_nxt;
        end
    end

    // Next state with cancel > select > insert priority, plus next output values
    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        result_nxt = result;
        take_nxt   = take;
        clr        = 1'b0;
        add_en     = 1'b0;
        sel_ok     = 1'b0;
        sel_price  = '0;
        hold_nxt   = 1'b0;
        d1_nxt     = 1'b0;
        d2_nxt     = 1'b0;
        tk_nxt     = 1'b0;
        ch_nxt     = 1'b0;
        sum_nxt    = '0;

        case (drink_op_t'(bus.drink_op))
            OP_D1: begin
                if (credit != '0 && credit >= P1) begin
                    sel_ok    = 1'b1;
                    sel_price = P1;
                end
            end
            OP_D2: begin
                if (credit != '0 && credit >= P2) begin
                    sel_ok    = 1'b1;
                    sel_price = P2;
                end
            end
            default: ;
        endcase

        if (state == SHOW) begin
            // Inputs ignored while the result is displayed
            if (cnt == '0) begin
                state_nxt  = IDLE;
                result_nxt = '0;
                take_nxt   = 1'b0;
            end else begin
                cnt_nxt = cnt - CNT_W'(1);
            end
        end else begin
            if (bus.cancel_flag && credit != '0) begin
                state_nxt  = SHOW;
                clr        = 1'b1;
                result_nxt = credit;
                take_nxt   = 1'b0;
                cnt_nxt    = CNT_LOAD;
            end else if (sel_ok) begin
                state_nxt  = SHOW;
                clr        = 1'b1;
                result_nxt = credit - sel_price;
                take_nxt   = 1'b1;
                cnt_nxt    = CNT_LOAD;
            end else if (bus.insert) begin
                add_en = 1'b1;
            end
            if (state_nxt != SHOW) begin
                state_nxt = credit_state(credit_nxt_c, P1, P2);
            end
        end

        if (state_nxt == SHOW) begin
            sum_nxt  = result_nxt;
            hold_nxt = 1'b1;
            tk_nxt   = take_nxt;
            ch_nxt   = !take_nxt || (result_nxt != '0);
        end else begin
            sum_nxt  = credit_nxt_c;
            hold_nxt = (credit_nxt_c != '0);
            d1_nxt   = (credit_nxt_c >= P1);
            d2_nxt   = (credit_nxt_c >= P2);
        end
    end

    // Registered Moore outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q <= 1'b0;
            d1_q   <= 1'b0;
            d2_q   <= 1'b0;
            tk_q   <= 1'b0;
            ch_q   <= 1'b0;
            sum_q  <= '0;
        end else begin
            hold_q <= hold_nxt;
            d1_q   <= d1_nxt;
            d2_q   <= d2_nxt;
            tk_q   <= tk_nxt;
            ch_q   <= ch_nxt;
            sum_q  <= sum_nxt;
        end
    end

    assign bus.hold_ind    = hold_q;
    assign bus.drink_1_ind = d1_q;
    assign bus.drink_2_ind = d2_q;
    assign bus.drinktk_ind = tk_q;
    assign bus.charge_ind  = ch_q;
    assign bus.coin_sum    = sum_q;

endmodule

// File: tb/tb_vending_fsm.sv
// Directed, table-driven bench for the vending controller.
module tb_vending_fsm;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    vending_fsm_if vif ();

    vending_fsm dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (vif.slave)
    );

    always #5 clk = ~clk;

    // Expected output packing: {hold, d1, d2, drinktk, charge, coin_sum[5:0]}
    typedef struct {
        logic        ins;
        logic [1:0]  cv;
        logic [1:0]  op;
        logic        cn;
        logic [10:0] exp;
    } vec_t;

    vec_t vecs[$];
    int   total = 0;
    int   bad   = 0;

    function automatic logic [10:0] outs(input logic h, input logic d1, input logic d2,
                                         input logic tk, input logic ch, input logic [5:0] s);
        return {h, d1, d2, tk, ch, s};
    endfunction

    function automatic logic [10:0] dut_outs();
        return {vif.hold_ind, vif.drink_1_ind, vif.drink_2_ind,
                vif.drinktk_ind, vif.charge_ind, vif.coin_sum};
    endfunction

    task automatic add(input logic ins, input logic [1:0] cv, input logic [1:0] op,
                       input logic cn, input logic [10:0] e);
        vec_t v;
        v.ins = ins; v.cv = cv; v.op = op; v.cn = cn; v.exp = e;
        vecs.push_back(v);
    endtask

    // Three more SHOW cycles with idle inputs, then back to idle
    task automatic add_show_tail(input logic tk, input logic ch, input logic [5:0] s);
        for (int k = 0; k < 3; k++) add(1'b0, 2'b00, 2'b00, 1'b0, outs(1, 0, 0, tk, ch, s));
        add(1'b0, 2'b00, 2'b00, 1'b0, outs(0, 0, 0, 0, 0, 6'd0));
    endtask

    task automatic check(input string name, input logic [10:0] got, input logic [10:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got h/d1/d2/tk/ch/sum=%b/%b/%b/%b/%b/%0d want %b/%b/%b/%b/%b/%0d",
                     name, got[10], got[9], got[8], got[7], got[6], got[5:0],
                     exp[10], exp[9], exp[8], exp[7], exp[6], exp[5:0]);
        end
    endtask

    task automatic drive(input logic ins, input logic [1:0] cv, input logic [1:0] op, input logic cn);
        vif.insert = ins; vif.coin_val = cv; vif.drink_op = op; vif.cancel_flag = cn;
    endtask

    task automatic step(input logic ins, input logic [1:0] cv, input logic [1:0] op, input logic cn);
        @(negedge clk);
        drive(ins, cv, op, cn);
        @(posedge clk);
        #1;
    endtask

    initial begin
        drive(1'b0, 2'b00, 2'b00, 1'b0);

        // 1 yuan then cancel: refund 2 for four cycles
        add(1, 2'b01, 2'b00, 0, outs(1, 0, 0, 0, 0, 6'd2));
        add(0, 2'b00, 2'b00, 1, outs(1, 0, 0, 0, 1, 6'd2));
        add_show_tail(0, 1, 6'd2);
        // Cancel and selection in IDLE are ignored
        add(0, 2'b00, 2'b00, 1, outs(0, 0, 0, 0, 0, 6'd0));
        add(0, 2'b00, 2'b01, 0, outs(0, 0, 0, 0, 0, 6'd0));
        // Three 1-yuan coins, drink 1 -> change 1
        add(1, 2'b01, 2'b00, 0, outs(1, 0, 0, 0, 0, 6'd2));
        add(1, 2'b01, 2'b00, 0, outs(1, 0, 0, 0, 0, 6'd4));
        add(1, 2'b01, 2'b00, 0, outs(1, 1, 0, 0, 0, 6'd6));
        add(0, 2'b00, 2'b01, 0, outs(1, 0, 0, 1, 1, 6'd1));
        add_show_tail(1, 1, 6'd1);
        // 10 yuan, drink 2 -> change 10
        add(1, 2'b10, 2'b00, 0, outs(1, 1, 1, 0, 0, 6'd20));
        add(0, 2'b00, 2'b10, 0, outs(1, 0, 0, 1, 1, 6'd10));
        add_show_tail(1, 1, 6'd10);
        // Unaffordable / reserved selections leave credit unchanged
        add(1, 2'b01, 2'b00, 0, outs(1, 0, 0, 0, 0, 6'd2));
        add(0, 2'b00, 2'b10, 0, outs(1, 0, 0, 0, 0, 6'd2));
        add(0, 2'b00, 2'b11, 0, outs(1, 0, 0, 0, 0, 6'd2));
        add(0, 2'b00, 2'b01, 0, outs(1, 0, 0, 0, 0, 6'd2));
        add(0, 2'b00, 2'b00, 1, outs(1, 0, 0, 0, 1, 6'd2));
        add_show_tail(0, 1, 6'd2);
        // Two half-yuan plus two 1-yuan = 6, drink 1 -> change 1
        add(1, 2'b11, 2'b00, 0, outs(1, 0, 0, 0, 0, 6'd1));
        add(1, 2'b11, 2'b00, 0, outs(1, 0, 0, 0, 0, 6'd2));
        add(1, 2'b01, 2'b00, 0, outs(1, 0, 0, 0, 0, 6'd4));
        add(1, 2'b01, 2'b00, 0, outs(1, 1, 0, 0, 0, 6'd6));
        add(0, 2'b00, 2'b01, 0, outs(1, 0, 0, 1, 1, 6'd1));
        add_show_tail(1, 1, 6'd1);
        // Exact price 5 -> no change
        add(1, 2'b11, 2'b00, 0, outs(1, 0, 0, 0, 0, 6'd1));
        add(1, 2'b01, 2'b00, 0, outs(1, 0, 0, 0, 0, 6'd3));
        add(1, 2'b01, 2'b00, 0, outs(1, 1, 0, 0, 0, 6'd5));
        add(0, 2'b00, 2'b01, 0, outs(1, 0, 0, 1, 0, 6'd0));
        add_show_tail(1, 0, 6'd0);
        // Saturation at 63
        add(1, 2'b10, 2'b00, 0, outs(1, 1, 1, 0, 0, 6'd20));
        add(1, 2'b10, 2'b00, 0, outs(1, 1, 1, 0, 0, 6'd40));
        add(1, 2'b10, 2'b00, 0, outs(1, 1, 1, 0, 0, 6'd60));
        add(1, 2'b10, 2'b00, 0, outs(1, 1, 1, 0, 0, 6'd63));
        // Cancel beats select: full refund of 63
        add(0, 2'b00, 2'b01, 1, outs(1, 0, 0, 0, 1, 6'd63));
        // Inputs during SHOW ignored, including on the exit edge
        for (int k = 0; k < 3; k++) add(1, 2'b10, 2'b10, 1, outs(1, 0, 0, 0, 1, 6'd63));
        add(1, 2'b01, 2'b01, 1, outs(0, 0, 0, 0, 0, 6'd0));
        // Select with simultaneous insert: insert discarded, change 15
        add(1, 2'b10, 2'b00, 0, outs(1, 1, 1, 0, 0, 6'd20));
        add(1, 2'b10, 2'b01, 0, outs(1, 0, 0, 1, 1, 6'd15));
        add_show_tail(1, 1, 6'd15);
        // insert with coin 00 adds nothing
        add(1, 2'b01, 2'b00, 0, outs(1, 0, 0, 0, 0, 6'd2));
        add(1, 2'b00, 2'b00, 0, outs(1, 0, 0, 0, 0, 6'd2));

        // Reset state
        #12;
        check("reset_state", dut_outs(), outs(0, 0, 0, 0, 0, 6'd0));
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].ins, vecs[i].cv, vecs[i].op, vecs[i].cn);
            check($sformatf("vec%0d", i), dut_outs(), vecs[i].exp);
        end

        // Async reset mid-credit (credit is 2 here)
        @(negedge clk);
        drive(1'b0, 2'b00, 2'b00, 1'b0);
        rst_n = 1'b0;
        #1;
        check("rst_mid_credit_now", dut_outs(), outs(0, 0, 0, 0, 0, 6'd0));
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b0, 2'b00, 2'b00, 1'b0);
        check("rst_credit_lost", dut_outs(), outs(0, 0, 0, 0, 0, 6'd0));

        // Async reset during SHOW
        step(1'b1, 2'b01, 2'b00, 1'b0);
        check("pre_show_credit", dut_outs(), outs(1, 0, 0, 0, 0, 6'd2));
        step(1'b0, 2'b00, 2'b00, 1'b1);
        check("show_refund", dut_outs(), outs(1, 0, 0, 0, 1, 6'd2));
        @(negedge clk);
        drive(1'b0, 2'b00, 2'b00, 1'b0);
        rst_n = 1'b0;
        #1;
        check("rst_in_show_now", dut_outs(), outs(0, 0, 0, 0, 0, 6'd0));
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, 2'b11, 2'b00, 1'b0);
        check("after_show_rst", dut_outs(), outs(1, 0, 0, 0, 0, 6'd1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
